// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: buffers input vectors and steps an LSTM layer one timestep at a time.
// Optional macro LSTM_SEQ_STEP_CNT_EN adds o_step, the index of o_h within its sequence.
module lstm_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int NUM      = 68,
  parameter int NUM_LSTM = 8,
  parameter int DEPTH    = 4,
  parameter int CELL_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [NUM*WIDTH-1:0]      i_data,
  input  logic                      i_last,
  output logic [NUM*WIDTH-1:0]      o_x,
  output logic                      o_sel,
  output logic                      o_load_h,
  input  logic [NUM_LSTM*WIDTH-1:0] i_h,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [NUM_LSTM*WIDTH-1:0] o_h,
  output logic                      o_last
`ifdef LSTM_SEQ_STEP_CNT_EN
  ,
  output logic [15:0]               o_step
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(CELL_LAT) + 1;
  localparam int XW = NUM * WIDTH;
  localparam int HW = NUM_LSTM * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LATCH, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            first_q, first_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [XW-1:0]   x_q, x_d;
  logic            sel_q, sel_d;
  logic            cur_last_q, cur_last_d;
  logic [HW-1:0]   h_q, h_d;
  logic            last_q, last_d;

  logic [XW:0]     fifo_mem_q [DEPTH];
  logic [XW:0]     rd_entry;
  logic            full, empty, push, pop;

`ifdef LSTM_SEQ_STEP_CNT_EN
  logic [15:0]     step_q, step_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Occupancy is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = i_valid && !full;
  assign rd_entry = fifo_mem_q[rd_ptr_q];

  assign i_ready  = !full;
  assign o_x      = x_q;
  assign o_sel    = sel_q;
  assign o_load_h = (state_q == S_LATCH);
  assign o_valid  = (state_q == S_EMIT);
  assign o_h      = h_q;
  assign o_last   = last_q;
`ifdef LSTM_SEQ_STEP_CNT_EN
  assign o_step   = step_q;
`endif

  // Storage is flushed by the pointers, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {i_last, i_data};
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    first_d    = first_q;
    lat_cnt_d  = lat_cnt_q;
    x_d        = x_q;
    sel_d      = sel_q;
    cur_last_d = cur_last_q;
    h_d        = h_q;
    last_d     = last_q;
    pop        = 1'b0;
`ifdef LSTM_SEQ_STEP_CNT_EN
    step_d     = step_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          x_d        = rd_entry[XW-1:0];
          cur_last_d = rd_entry[XW];
          sel_d      = !first_q;
          first_d    = 1'b0;
          lat_cnt_d  = LW'(CELL_LAT - 1);
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (lat_cnt_q == '0) state_d = S_LATCH;
        else                 lat_cnt_d = lat_cnt_q - LW'(1);
      end
      S_LATCH: begin
        h_d     = i_h;
        last_d  = cur_last_q;
        state_d = S_EMIT;
`ifdef LSTM_SEQ_STEP_CNT_EN
        // A zero-h_prev step is always index 0 of its sequence.
        step_d  = sel_q ? sat_inc16(step_q) : 16'd0;
`endif
      end
      S_EMIT: begin
        if (o_ready) begin
          state_d = S_IDLE;
          if (last_q) first_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      first_q    <= 1'b1;
      lat_cnt_q  <= '0;
      x_q        <= '0;
      sel_q      <= 1'b0;
      cur_last_q <= 1'b0;
      h_q        <= '0;
      last_q     <= 1'b0;
`ifdef LSTM_SEQ_STEP_CNT_EN
      step_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      first_q    <= first_d;
      lat_cnt_q  <= lat_cnt_d;
      x_q        <= x_d;
      sel_q      <= sel_d;
      cur_last_q <= cur_last_d;
      h_q        <= h_d;
      last_q     <= last_d;
`ifdef LSTM_SEQ_STEP_CNT_EN
      step_q     <= step_d;
`endif
    end
  end

endmodule
